// File: rtl/i2s_rx_pkg.sv
// Shared I2S framing constants and helpers for the I2S receiver.
package i2s_rx_pkg;

    localparam int I2S_SLOT_BITS = 32;
    localparam int I2S_CNT_W     = 6;

    localparam logic I2S_LEFT  = 1'b0;
    localparam logic I2S_RIGHT = 1'b1;

    function automatic logic [I2S_CNT_W-1:0] cnt_sat_inc(input logic [I2S_CNT_W-1:0] cnt);
        return (cnt == '1) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/i2s_rx.sv
// I2S receiver: oversampled BCLK/LRCLK, MSB-first slots, stereo pairs out on valid/ready.
// Optional slot-length check enabled by `define I2S_RX_FRAME_CHECK_EN.
module i2s_rx
    import i2s_rx_pkg::*;
#(
    parameter int DATA_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bclk_rising,
    input  logic                 lrclk,
    input  logic                 sdata,
    output logic [DATA_BITS-1:0] left_data,
    output logic [DATA_BITS-1:0] right_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overrun,
    input  logic                 overrun_clr,
    output logic                 frame_err
);

    localparam logic [I2S_CNT_W-1:0] DATA_CNT = I2S_CNT_W'(DATA_BITS);

    logic [I2S_CNT_W-1:0] bit_cnt_q,    bit_cnt_d;
    logic                 lrclk_prev_q, lrclk_prev_d;
    logic                 armed_q,      armed_d;
    logic [DATA_BITS-1:0] shreg_q,      shreg_d;
    logic [DATA_BITS-1:0] left_hold_q,  left_hold_d;
    logic                 left_seen_q,  left_seen_d;
    logic [DATA_BITS-1:0] left_data_q,  left_data_d;
    logic [DATA_BITS-1:0] right_data_q, right_data_d;
    logic                 out_valid_q,  out_valid_d;
    logic                 overrun_q,    overrun_d;

    logic                 lr_edge;
    logic [I2S_CNT_W-1:0] cnt_next;
    logic [DATA_BITS-1:0] word;
    logic                 publish;

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        lrclk_prev_d = lrclk_prev_q;
        armed_d      = armed_q;
        shreg_d      = shreg_q;
        left_hold_d  = left_hold_q;
        left_seen_d  = left_seen_q;
        left_data_d  = left_data_q;
        right_data_d = right_data_q;
        out_valid_d  = out_valid_q;
        overrun_d    = overrun_q;
        publish      = 1'b0;

        lr_edge  = (lrclk != lrclk_prev_q);
        cnt_next = cnt_sat_inc(bit_cnt_q);
        word     = {shreg_q[DATA_BITS-2:0], sdata};

        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (overrun_clr)              overrun_d   = 1'b0;

        if (bclk_rising) begin
            lrclk_prev_d = lrclk;
            if (lr_edge) begin
                // Slot start: this strobe is the delay bit, sdata ignored.
                armed_d   = 1'b1;
                bit_cnt_d = '0;
                if (armed_q && (bit_cnt_q < DATA_CNT) && (lrclk_prev_q == I2S_LEFT))
                    left_seen_d = 1'b0;
            end else if (armed_q) begin
                bit_cnt_d = cnt_next;
                if (cnt_next <= DATA_CNT) shreg_d = word;
                if (cnt_next == DATA_CNT) begin
                    if (lrclk_prev_q == I2S_LEFT) begin
                        left_hold_d = word;
                        left_seen_d = 1'b1;
                    end else if (left_seen_q) begin
                        publish = 1'b1;
                    end
                end
            end
        end

        if (publish) begin
            left_data_d  = left_hold_q;
            right_data_d = word;
            out_valid_d  = 1'b1;
            left_seen_d  = 1'b0;
            if (out_valid_q && !out_ready) overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q    <= '0;
            lrclk_prev_q <= 1'b0;
            armed_q      <= 1'b0;
            shreg_q      <= '0;
            left_hold_q  <= '0;
            left_seen_q  <= 1'b0;
            left_data_q  <= '0;
            right_data_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            lrclk_prev_q <= lrclk_prev_d;
            armed_q      <= armed_d;
            shreg_q      <= shreg_d;
            left_hold_q  <= left_hold_d;
            left_seen_q  <= left_seen_d;
            left_data_q  <= left_data_d;
            right_data_q <= right_data_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    localparam logic [I2S_CNT_W-1:0] LAST_SLOT_CNT = I2S_CNT_W'(I2S_SLOT_BITS - 1);

    logic frame_err_q, frame_err_d;

    // armed_q low marks the first edge after reset, which is exempt.
    always_comb begin
        frame_err_d = frame_err_q;
        if (bclk_rising && lr_edge && armed_q && (bit_cnt_q != LAST_SLOT_CNT))
            frame_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_err_q <= 1'b0;
        else        frame_err_q <= frame_err_d;
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign left_data  = left_data_q;
    assign right_data = right_data_q;
    assign out_valid  = out_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: table of full frames plus hand sequences for truncation,
// accept-during-publish and mid-slot reset.
module tb_i2s_rx;

    localparam int DB = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bclk_rising;
    logic          lrclk;
    logic          sdata;
    logic [DB-1:0] left_data;
    logic [DB-1:0] right_data;
    logic          out_valid;
    logic          out_ready;
    logic          overrun;
    logic          overrun_clr;
    logic          frame_err;

    int errors = 0;
    int checks = 0;

    i2s_rx #(.DATA_BITS(DB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bclk_rising (bclk_rising),
        .lrclk       (lrclk),
        .sdata       (sdata),
        .left_data   (left_data),
        .right_data  (right_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DB-1:0] l;
        logic [DB-1:0] r;
        bit            acc;
        bit            clr;
        logic          e_valid;
        logic [DB-1:0] e_l;
        logic [DB-1:0] e_r;
        logic          e_ovr;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic lr, input logic sd, input bit rdy);
        @(posedge clk); #1;
        bclk_rising = 1'b1;
        lrclk       = lr;
        sdata       = sd;
        if (rdy) out_ready = 1'b1;
        @(posedge clk); #1;
        bclk_rising = 1'b0;
        if (rdy) out_ready = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // Strobe 0 is the delay bit; 1..DB carry the word MSB-first; the rest is padding.
    // Delay and padding bits are driven 1 so any stray capture shows up.
    task automatic send_slot(input logic lr, input logic [DB-1:0] w, input int n, input int rdy_bit);
        logic sd;
        for (int i = 0; i < n; i++) begin
            sd = (i >= 1 && i <= DB) ? w[DB-i] : 1'b1;
            strobe(lr, sd, (rdy_bit != 0) && (i == rdy_bit));
        end
    endtask

    task automatic send_frame(input logic [DB-1:0] l, input logic [DB-1:0] r);
        send_slot(1'b0, l, 32, 0);
        send_slot(1'b1, r, 32, 0);
    endtask

    task automatic accept_pulse();
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
    endtask

    logic exp_ferr;
    logic [DB-1:0] rl, rr;

    initial begin
`ifdef I2S_RX_FRAME_CHECK_EN
        exp_ferr = 1'b1;
`else
        exp_ferr = 1'b0;
`endif
        vecs[0] = '{24'hA5A5A5, 24'h3C3C3C, 1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000, 1'b0};
        vecs[1] = '{24'hA5A5A5, 24'h3C3C3C, 1'b0, 1'b0, 1'b1, 24'hA5A5A5, 24'h3C3C3C, 1'b0};
        vecs[2] = '{24'h123456, 24'hFEDCBA, 1'b1, 1'b1, 1'b1, 24'h123456, 24'hFEDCBA, 1'b1};
        vecs[3] = '{24'h800001, 24'h7FFFFE, 1'b1, 1'b0, 1'b1, 24'h800001, 24'h7FFFFE, 1'b0};
        vecs[4] = '{24'hFFFFFF, 24'h000000, 1'b0, 1'b0, 1'b1, 24'hFFFFFF, 24'h000000, 1'b0};

        rst_n = 1'b0; bclk_rising = 1'b0; lrclk = 1'b0; sdata = 1'b0;
        out_ready = 1'b0; overrun_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_left", 32'(left_data), 32'h0);
        check("rst_right", 32'(right_data), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].l, vecs[i].r);
            @(negedge clk);
            check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d_left", i), 32'(left_data), 32'(vecs[i].e_l));
            check($sformatf("v%0d_right", i), 32'(right_data), 32'(vecs[i].e_r));
            check($sformatf("v%0d_overrun", i), 32'(overrun), 32'(vecs[i].e_ovr));
            if (vecs[i].acc) begin
                accept_pulse();
                check($sformatf("v%0d_accept", i), 32'(out_valid), 32'h0);
                check($sformatf("v%0d_hold_left", i), 32'(left_data), 32'(vecs[i].e_l));
            end
            if (vecs[i].clr) begin
                @(posedge clk); #1 overrun_clr = 1'b1;
                @(posedge clk); #1 overrun_clr = 1'b0;
                @(negedge clk);
                check($sformatf("v%0d_ovr_clr", i), 32'(overrun), 32'h0);
            end
        end

        accept_pulse();
        for (int k = 0; k < 3; k++) begin
            rl = DB'($urandom);
            rr = DB'($urandom);
            send_frame(rl, rr);
            @(negedge clk);
            check($sformatf("rnd%0d_valid", k), 32'(out_valid), 32'h1);
            check($sformatf("rnd%0d_left", k), 32'(left_data), 32'(rl));
            check($sformatf("rnd%0d_right", k), 32'(right_data), 32'(rr));
            accept_pulse();
        end

        // Left slot cut after 10 data bits: the following right must be dropped.
        send_slot(1'b0, 24'h555555, 11, 0);
        send_slot(1'b1, 24'hAAAAAA, 32, 0);
        @(negedge clk);
        check("trunc_valid", 32'(out_valid), 32'h0);
        check("trunc_frame_err", 32'(frame_err), 32'(exp_ferr));
        send_frame(24'h0F0F0F, 24'hF0F0F0);
        @(negedge clk);
        check("post_trunc_valid", 32'(out_valid), 32'h1);
        check("post_trunc_left", 32'(left_data), 32'h0F0F0F);
        check("post_trunc_right", 32'(right_data), 32'hF0F0F0);

        // out_ready asserted exactly on the publishing strobe while the old pair is pending.
        send_slot(1'b0, 24'h13579B, 32, 0);
        send_slot(1'b1, 24'h2468AC, 32, DB);
        @(negedge clk);
        check("same_cyc_valid", 32'(out_valid), 32'h1);
        check("same_cyc_left", 32'(left_data), 32'h13579B);
        check("same_cyc_right", 32'(right_data), 32'h2468AC);
        check("same_cyc_overrun", 32'(overrun), 32'h0);

        // Asynchronous reset in the middle of a right slot.
        send_slot(1'b0, 24'hC0FFEE, 32, 0);
        send_slot(1'b1, 24'hBADBAD, 12, 0);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_left", 32'(left_data), 32'h0);
        check("mid_rst_right", 32'(right_data), 32'h0);
        check("mid_rst_overrun", 32'(overrun), 32'h0);
        check("mid_rst_frame_err", 32'(frame_err), 32'h0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        send_slot(1'b1, 24'h000000, 20, 0);
        @(negedge clk);
        check("rst_right_dropped", 32'(out_valid), 32'h0);
        send_frame(24'h600DF0, 24'h0DDBA1);
        @(negedge clk);
        check("resume_valid", 32'(out_valid), 32'h1);
        check("resume_left", 32'(left_data), 32'h600DF0);
        check("resume_right", 32'(right_data), 32'h0DDBA1);
        check("resume_overrun", 32'(overrun), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
